// File: rtl/console_cursor.sv
// Text-console cursor controller: turns a byte stream into single-cell
// (location, glyph) writes for a COLS x ROWS character RAM, with a
// hardware clear sweep that fills every cell with a space.
module console_cursor #(
  parameter int unsigned COLS   = 32,
  parameter int unsigned ROWS   = 8,
  parameter int unsigned TAB    = 4,
  parameter int unsigned SCROLL = 1,
  localparam int unsigned LW    = $clog2(COLS * ROWS),
  localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned CW    = $clog2(COLS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          write,
  input  logic          clear,
  input  logic [7:0]    character,
  output logic          ready,
  output logic          write_flag,
  output logic [LW-1:0] location,
  output logic [7:0]    glyph,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          scroll
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [LW-1:0] LAST_CELL = LW'(COLS * ROWS - 1);
  localparam logic [7:0]    SPACE     = 8'h20;

  state_t        state;
  logic [LW-1:0] cur_loc;
  logic [RW-1:0] nrow;
  logic [CW-1:0] ncol;
  logic          nwr;
  logic          nscroll;
  logic [7:0]    nglyph;
  logic [LW-1:0] nloc;
  logic          adv;
  int unsigned   tab_stop;

  assign ready   = (state == IDLE);
  assign cur_loc = LW'(row) * LW'(COLS) + LW'(col);

  // Decode the current character into the next cursor position and cell write
  always_comb begin
    nrow     = row;
    ncol     = col;
    nwr      = 1'b0;
    nscroll  = 1'b0;
    nglyph   = character;
    nloc     = cur_loc;
    adv      = 1'b0;
    tab_stop = ((32'(col) / TAB) + 32'd1) * TAB;
    if (character >= 8'h20 && character <= 8'h7E) begin
      nwr = 1'b1;
      if (col == CW'(COLS - 1)) begin
        ncol = '0;
        adv  = 1'b1;
      end else begin
        ncol = col + CW'(1);
      end
    end else begin
      case (character)
        8'h0A: adv = 1'b1;
        8'h0D: ncol = '0;
        8'h08: begin
          if (col != '0) begin
            ncol   = col - CW'(1);
            nwr    = 1'b1;
            nglyph = SPACE;
            nloc   = cur_loc - LW'(1);
          end
        end
        8'h09: begin
          if (tab_stop >= COLS) begin
            ncol = '0;
            adv  = 1'b1;
          end else begin
            ncol = CW'(tab_stop);
          end
        end
        default: ;
      endcase
    end
    // Bottom-row overflow either holds the row and requests a scroll, or wraps
    if (adv) begin
      if (row != RW'(ROWS - 1)) begin
        nrow = row + RW'(1);
      end else if (SCROLL != 0) begin
        nscroll = 1'b1;
      end else begin
        nrow = '0;
      end
    end
  end

  // Control FSM with registered write command, cursor and scroll outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      location   <= '0;
      glyph      <= '0;
      write_flag <= 1'b0;
      scroll     <= 1'b0;
    end else begin
      write_flag <= 1'b0;
      scroll     <= 1'b0;
      case (state)
        IDLE: begin
          if (clear) begin
            state      <= CLEAR;
            write_flag <= 1'b1;
            location   <= '0;
            glyph      <= SPACE;
          end else if (write) begin
            row        <= nrow;
            col        <= ncol;
            write_flag <= nwr;
            scroll     <= nscroll;
            if (nwr) begin
              location <= nloc;
              glyph    <= nglyph;
            end
          end
        end
        CLEAR: begin
          // location doubles as the sweep counter
          if (location == LAST_CELL) begin
            state <= IDLE;
            row   <= '0;
            col   <= '0;
          end else begin
            location   <= location + LW'(1);
            write_flag <= 1'b1;
            glyph      <= SPACE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_console_cursor.sv
// Bench for console_cursor: directed steps plus random bytes, checked against
// a cursor/cell model. Two instances share stimulus: scroll and wrap modes.
module tb_console_cursor;

  localparam int COLS = 32;
  localparam int ROWS = 8;
  localparam int TABS = 4;
  localparam int N    = COLS * ROWS;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       write = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] character = 8'h00;

  logic       rdy0, wf0, sc0, rdy1, wf1, sc1;
  logic [7:0] loc0, gl0, loc1, gl1;
  logic [2:0] row0, row1;
  logic [4:0] col0, col1;

  int vectors = 0;
  int errors  = 0;

  // model state per instance: 0 = scroll mode, 1 = wrap mode
  int mrow[2], mcol[2], mloc[2], mglyph[2], mwf[2], msc[2];
  int mready;

  always #5 clock = ~clock;

  console_cursor #(.COLS(COLS), .ROWS(ROWS), .TAB(TABS), .SCROLL(1)) u0 (
    .clock(clock), .reset(reset), .write(write), .clear(clear),
    .character(character), .ready(rdy0), .write_flag(wf0), .location(loc0),
    .glyph(gl0), .row(row0), .col(col0), .scroll(sc0));

  console_cursor #(.COLS(COLS), .ROWS(ROWS), .TAB(TABS), .SCROLL(0)) u1 (
    .clock(clock), .reset(reset), .write(write), .clear(clear),
    .character(character), .ready(rdy1), .write_flag(wf1), .location(loc1),
    .glyph(gl1), .row(row1), .col(col1), .scroll(sc1));

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_inst(string nm, int k, logic wf, logic [7:0] loc,
                            logic [7:0] gl, logic [2:0] r, logic [4:0] c,
                            logic sc, logic rdy, bit chk_rdy);
    chk({nm, ".write_flag"}, 32'(wf), 32'(mwf[k]));
    chk({nm, ".location"}, 32'(loc), 32'(mloc[k]));
    chk({nm, ".glyph"}, 32'(gl), 32'(mglyph[k]));
    chk({nm, ".row"}, 32'(r), 32'(mrow[k]));
    chk({nm, ".col"}, 32'(c), 32'(mcol[k]));
    chk({nm, ".scroll"}, 32'(sc), 32'(msc[k]));
    if (chk_rdy) chk({nm, ".ready"}, 32'(rdy), 32'(mready));
  endtask

  task automatic check_all(bit chk_rdy);
    check_inst("scroll", 0, wf0, loc0, gl0, row0, col0, sc0, rdy0, chk_rdy);
    check_inst("wrap", 1, wf1, loc1, gl1, row1, col1, sc1, rdy1, chk_rdy);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mrow[k] = 0; mcol[k] = 0; mloc[k] = 0; mglyph[k] = 0;
      mwf[k] = 0; msc[k] = 0;
    end
    mready = 1;
  endtask

  task automatic model_idle();
    for (int k = 0; k < 2; k++) begin
      mwf[k] = 0; msc[k] = 0;
    end
  endtask

  // Reference behaviour for one accepted byte
  task automatic model_char(logic [7:0] ch);
    for (int k = 0; k < 2; k++) begin
      bit advance = 0;
      mwf[k] = 0; msc[k] = 0;
      if (ch >= 8'h20 && ch <= 8'h7E) begin
        mwf[k] = 1; mloc[k] = mrow[k] * COLS + mcol[k]; mglyph[k] = int'(ch);
        mcol[k] = mcol[k] + 1;
        if (mcol[k] == COLS) begin mcol[k] = 0; advance = 1; end
      end else if (ch == 8'h0A) begin
        advance = 1;
      end else if (ch == 8'h0D) begin
        mcol[k] = 0;
      end else if (ch == 8'h08) begin
        if (mcol[k] > 0) begin
          mcol[k] = mcol[k] - 1;
          mwf[k] = 1; mloc[k] = mrow[k] * COLS + mcol[k]; mglyph[k] = 32;
        end
      end else if (ch == 8'h09) begin
        mcol[k] = (mcol[k] / TABS + 1) * TABS;
        if (mcol[k] >= COLS) begin mcol[k] = 0; advance = 1; end
      end
      if (advance) begin
        if (mrow[k] < ROWS - 1) mrow[k] = mrow[k] + 1;
        else if (k == 0) msc[k] = 1;
        else mrow[k] = 0;
      end
    end
  endtask

  task automatic send(logic [7:0] ch);
    write = 1'b1; character = ch;
    @(posedge clock); #1;
    write = 1'b0;
    model_char(ch);
    check_all(1);
  endtask

  task automatic idle_cycle();
    write = 1'b0;
    @(posedge clock); #1;
    model_idle();
    check_all(1);
  endtask

  // Clear sweep; optional byte offered in the same cycle, optional reset abort
  task automatic do_clear(bit with_write, int abort_at);
    clear = 1'b1; write = with_write; character = "X";
    @(posedge clock); #1;
    clear = 1'b0; write = 1'b0;
    mready = 0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 2; k++) begin
        mwf[k] = 1; mloc[k] = i; mglyph[k] = 32; msc[k] = 0;
      end
      check_all(1);
      if (i == abort_at) begin
        reset = 1'b1;
        #2;
        model_reset();
        check_all(0);
        reset = 1'b0;
        return;
      end
      write = 1'($urandom_range(0, 1));
      clear = 1'($urandom_range(0, 1));
      character = 8'($urandom_range(0, 255));
      @(posedge clock); #1;
      write = 1'b0; clear = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      mwf[k] = 0; mrow[k] = 0; mcol[k] = 0;
    end
    mready = 1;
    check_all(1);
  endtask

  function automatic logic [7:0] rand_byte();
    case ($urandom_range(0, 9))
      0: return 8'h0A;
      1: return 8'h0D;
      2: return 8'h08;
      3: return 8'h09;
      4: return 8'($urandom_range(0, 255));
      default: return 8'($urandom_range(32, 126));
    endcase
  endfunction

  initial begin
    model_reset();
    #3;
    check_all(0);
    @(posedge clock); #1;
    reset = 1'b0;
    idle_cycle();

    // back-to-back printable bytes
    send("A"); send("B");

    // full line from column 0, then CR/BS at column 0
    send(8'h0D);
    for (int i = 0; i < COLS; i++) send(8'($urandom_range(33, 126)));
    send(8'h0D); send(8'h08);

    // bottom-row LF: scroll holds row, wrap returns to row 0
    do_clear(0, -1);
    for (int i = 0; i < 7; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send("c");
    send(8'h0A);
    idle_cycle();

    // TAB past the last stop, then BS erasing a cell
    send(8'h0D);
    for (int i = 0; i < 30; i++) send("t");
    send(8'h09);
    send(8'h0D);
    for (int i = 0; i < 5; i++) send("u");
    send(8'h08);
    send(8'h09); send(8'h09);

    // clear with a simultaneous write that must be dropped
    do_clear(1, -1);
    idle_cycle();

    // random byte stream with occasional idle cycles
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) idle_cycle();
      else send(rand_byte());
    end

    // reset in the middle of a sweep
    do_clear(0, 100);
    idle_cycle();
    send("A");
    idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/console_cursor.md
Name: console_cursor

Overview:
- Parametrised text-console cursor controller. It turns a byte stream into single-cell write commands (location, glyph) for a COLS x ROWS character display RAM.
- Handles printable characters, CR, LF, backspace and tab, and supports scroll or wrap on bottom-row overflow.
- Clear is performed as a hardware sweep that writes a space to every cell.
- Sits between the character source (UART/CPU port) and the display memory.

Parameters:
- COLS, 32, characters per line (>=2, need not be a power of two)
- ROWS, 8, lines on the display (>=1)
- TAB, 4, tab stop spacing in columns (1..COLS)
- SCROLL, 1, 1 = bottom-row overflow holds the row and pulses scroll; 0 = row wraps to 0

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- write  input  1  character strobe; accepted when write && ready
- clear  input  1  request full-screen clear sweep
- character  input  8  byte to process
- ready  output  1  high in IDLE; low during the clear sweep
- write_flag  output  1  one-cycle pulse: write glyph to location
- location  output  LW  cell index row*COLS+col; LW = $clog2(COLS*ROWS)
- glyph  output  8  byte to store at location
- row  output  $clog2(ROWS) (min 1)  current cursor row
- col  output  $clog2(COLS)  current cursor column
- scroll  output  1  one-cycle pulse: display must shift up one line (SCROLL=1 only)

Behaviour:
- Reset (asynchronous): state=IDLE; row, col, location, glyph = 0; write_flag, scroll = 0; ready = 1 once reset is released.
- All outputs are registered. write_flag, location, glyph, scroll and the updated row/col all appear on the cycle after acceptance. ready = (state==IDLE), combinational from state.
- The character is only sampled when write && ready.
- Priority in IDLE: clear beats write. If both are high in the same cycle, the character is discarded.
- Printable (0x20..0x7E):
  - Emit write_flag=1, glyph=character, location=row*COLS+col (the pre-advance cursor).
  - If col==COLS-1: col=0 and do a line advance. Otherwise col+1.
- LF (0x0A): line advance only; col unchanged; no cell write.
- CR (0x0D): col=0; no cell write.
- BS (0x08):
  - If col>0: col-1, and emit a write of 0x20 at the new position (row*COLS+col-1).
  - If col==0: no-op (no reverse line wrap).
- TAB (0x09): col = next multiple of TAB strictly greater than col. If that is >=COLS: col=0 and line advance. No cell write.
- Any other byte: consumed, no effect.
- Line advance:
  - If row<ROWS-1: row+1.
  - If row==ROWS-1 and SCROLL=1: row holds and scroll pulses for 1 cycle, coincident with any write_flag from the same character.
  - If row==ROWS-1 and SCROLL=0: row=0, no scroll pulse.
- Clear sweep:
  - IDLE & clear -> CLEAR.
  - In CLEAR, one write per cycle: write_flag=1, glyph=0x20, location = 0,1,...,COLS*ROWS-1.
  - After the last cell, row=col=0 and return to IDLE (ready=1 the following cycle).
  - The sweep takes exactly COLS*ROWS cycles with write_flag high.
  - write and clear are both ignored during CLEAR.
- Reset mid-sweep aborts immediately to the reset state. The display is left partially cleared; this is allowed.
- Arithmetic:
  - location is computed as a row*COLS + col multiply-add at width LW; it never exceeds COLS*ROWS-1.
  - row and col never leave 0..ROWS-1 and 0..COLS-1.
- write_flag is never high for two consecutive cycles in IDLE unless write is held with successive printable/BS bytes. Throughput is 1 char/cycle.

Test Plan:
1. Default params, reset, write 'A','B' back-to-back -> write_flag pulses with location 0 then 1, glyph 0x41 then 0x42; col=2, row=0.
2. Write 32 printable chars from (0,0) -> last write at location 31; then row=1, col=0. Then CR, BS -> col stays 0, no write_flag.
3. Cursor at (7,5), SCROLL=1, write LF -> row=7, col=5, scroll=1 for one cycle. Same with SCROLL=0 -> row=0, col=5, no scroll.
4. col=30, write TAB (TAB=4) -> col=0, row+1. col=5, write BS -> write_flag with glyph 0x20 at row*32+4, col=4.
5. Assert clear together with write 'X' -> 'X' dropped; ready low for 256 cycles; write_flag high 256 cycles with locations 0..255 and glyph 0x20; then row=col=0, ready=1. Write pulses during the sweep have no effect.
6. Assert reset at sweep location 100 -> all outputs 0 immediately (asynchronous); ready=1 after deassert; next 'A' writes location 0.
